// File: rtl/mon8c2_report_collector.sv
// Collects 40-bit automata report snapshots into a stamped FIFO and serializes them as events.
// Optional sticky report summary output is enabled by defining MON8C2_SUMMARY_EN.
module mon8c2_report_collector #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [39:0]      report_vec,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] ev_cycle,
  output logic [3:0]       ev_ltl,
  output logic [1:0]       ev_rep,
  output logic             overflow,
  output logic [7:0]       drop_cnt,
`ifdef MON8C2_SUMMARY_EN
  output logic [39:0]      summary,
`endif
  output logic             busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = CNT_W + 40;
  localparam logic [AW:0] CntFull = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [EW-1:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic [39:0]       work_q, work_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_q, drop_d;
  logic              push_req, push, drop, pop, full;
  logic [5:0]        low_idx;
  logic [39:0]       low_onehot;

  // Lowest set bit of the working vector selects the presented event.
  always_comb begin
    low_idx = '0;
    for (int i = 39; i >= 0; i--) begin
      if (work_q[i]) low_idx = 6'(i);
    end
    low_onehot = 40'd1 << low_idx;
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cyc_d    = cyc_q;
    pop      = 1'b0;
    ev_valid = 1'b0;
    case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StLoad;
      end
      StLoad: begin
        {cyc_d, work_d} = mem_q[rptr_q];
        pop             = 1'b1;
        state_d         = StEmit;
      end
      StEmit: begin
        ev_valid = 1'b1;
        if (ev_ready) begin
          work_d = work_q & ~low_onehot;
          if (work_d == '0) state_d = (count_q != '0) ? StLoad : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Fullness uses the pre-pop count, so a same-cycle pop never rescues a push.
  always_comb begin
    full       = (count_q == CntFull);
    push_req   = run && (report_vec != '0);
    push       = push_req && !full;
    drop       = push_req && full;
    cnt_d      = run ? cnt_q + 1'b1 : cnt_q;
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    drop_d     = (drop && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;
    if (push) begin
      mem_d[wptr_q] = {cnt_q, report_vec};
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mem_q      <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      work_q     <= '0;
      cyc_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      work_q     <= work_d;
      cyc_q      <= cyc_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

`ifdef MON8C2_SUMMARY_EN
  logic [39:0] summary_q, summary_d;

  always_comb begin
    summary_d = run ? (summary_q | report_vec) : summary_q;
  end

  always_ff @(posedge clk) begin
    if (reset) summary_q <= '0;
    else       summary_q <= summary_d;
  end

  assign summary = summary_q;
`endif

  assign ev_cycle = cyc_q;
  assign ev_ltl   = low_idx[5:2];
  assign ev_rep   = low_idx[1:0];
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;
  assign busy     = (count_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_mon8c2_report_collector.sv
// Self-checking bench for mon8c2_report_collector: vector table, corner sequences, random vs model.
module tb_mon8c2_report_collector;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = 32;

  logic             clk = 1'b0;
  logic             reset, run, ev_ready;
  logic [39:0]      report_vec;
  logic             ev_valid, overflow, busy;
  logic [CNT_W-1:0] ev_cycle;
  logic [3:0]       ev_ltl;
  logic [1:0]       ev_rep;
  logic [7:0]       drop_cnt;
`ifdef MON8C2_SUMMARY_EN
  logic [39:0]      summary;
`endif

  mon8c2_report_collector #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .report_vec(report_vec),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_cycle(ev_cycle),
    .ev_ltl(ev_ltl), .ev_rep(ev_rep), .overflow(overflow), .drop_cnt(drop_cnt),
`ifdef MON8C2_SUMMARY_EN
    .summary(summary),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        run;
    logic [39:0] vec;
    logic        rdy;
    logic        v;
    logic [31:0] cyc;
    logic [3:0]  ltl;
    logic [1:0]  rep;
    logic        busy;
  } vec_t;

  typedef struct {
    logic [31:0] cyc;
    logic [3:0]  ltl;
    logic [1:0]  rep;
    bit          last;
  } ev_t;

  vec_t        tbl [16];
  ev_t         evq [$];
  logic [31:0] mcnt;
  bit          stall;
  logic [31:0] p_cyc;
  logic [3:0]  p_ltl;
  logic [1:0]  p_rep;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; report_vec = '0; ev_ready = 1'b0;
    tick();
    reset = 1'b0;
    evq.delete();
    mcnt  = '0;
    stall = 1'b0;
  endtask

  function automatic int outstanding();
    int n = 0;
    foreach (evq[i]) if (evq[i].last) n++;
    return n;
  endfunction

  function automatic logic [39:0] rand_vec();
    logic [39:0] v = '0;
    int n = $urandom_range(1, 3);
    for (int k = 0; k < n; k++) v[$urandom_range(0, 39)] = 1'b1;
    return v;
  endfunction

  // Model: each run=1 clock with a nonzero vector queues one event per set bit, ascending,
  // stamped with the number of run=1 clocks seen before it.
  task automatic drive_cycle(input logic r, input logic [39:0] v, input logic rd);
    ev_t e;
    run = r; report_vec = v; ev_ready = rd;
    if (stall) begin
      chk("hold_valid", ev_valid, 1);
      chk("hold_cycle", ev_cycle, p_cyc);
      chk("hold_ltl", ev_ltl, p_ltl);
      chk("hold_rep", ev_rep, p_rep);
    end
    if (ev_valid && rd) begin
      if (evq.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_event: got ltl=%0d rep=%0d cycle=%0d expected none",
                 ev_ltl, ev_rep, ev_cycle);
      end else begin
        e = evq.pop_front();
        chk("ev_cycle", ev_cycle, e.cyc);
        chk("ev_ltl", ev_ltl, e.ltl);
        chk("ev_rep", ev_rep, e.rep);
      end
    end
    stall = ev_valid && !rd;
    p_cyc = ev_cycle; p_ltl = ev_ltl; p_rep = ev_rep;
    if (r && v != '0) begin
      for (int b = 0; b < 40; b++) begin
        if (v[b]) begin
          e.cyc  = mcnt;
          e.ltl  = 4'(b / 4);
          e.rep  = 2'(b % 4);
          e.last = ((v >> (b + 1)) == '0);
          evq.push_back(e);
        end
      end
    end
    if (r) mcnt++;
    tick();
  endtask

  initial begin
    int got;
    logic [39:0] v;
    logic r, rd;

    // Cycle-by-cycle vectors after reset: bit 0 at counter 5, then bits 0,5,39 at counter 9.
    tbl[0]  = '{1'b1, 40'h0, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0, 1'b0};
    for (int i = 1; i < 5; i++) tbl[i] = tbl[0];
    tbl[5]  = '{1'b1, 40'h1, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0, 1'b0};
    tbl[6]  = '{1'b1, 40'h0, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0, 1'b1};
    tbl[7]  = '{1'b1, 40'h0, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0, 1'b1};
    tbl[8]  = '{1'b1, 40'h0, 1'b1, 1'b1, 32'd5, 4'd0, 2'd0, 1'b1};
    tbl[9]  = '{1'b1, 40'h80_0000_0021, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0, 1'b0};
    tbl[10] = '{1'b1, 40'h0, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0, 1'b1};
    tbl[11] = '{1'b1, 40'h0, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0, 1'b1};
    tbl[12] = '{1'b1, 40'h0, 1'b1, 1'b1, 32'd9, 4'd0, 2'd0, 1'b1};
    tbl[13] = '{1'b1, 40'h0, 1'b1, 1'b1, 32'd9, 4'd1, 2'd1, 1'b1};
    tbl[14] = '{1'b1, 40'h0, 1'b1, 1'b1, 32'd9, 4'd9, 2'd3, 1'b1};
    tbl[15] = '{1'b1, 40'h0, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0, 1'b0};

    reset = 1'b1; run = 1'b0; report_vec = '0; ev_ready = 1'b0;
    tick();
    do_reset();
    chk("rst_valid", ev_valid, 0);
    chk("rst_cycle", ev_cycle, 0);
    chk("rst_ltl", ev_ltl, 0);
    chk("rst_rep", ev_rep, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_cnt, 0);

    for (int i = 0; i < 16; i++) begin
      run = tbl[i].run; report_vec = tbl[i].vec; ev_ready = tbl[i].rdy;
      chk($sformatf("tbl%0d_valid", i), ev_valid, tbl[i].v);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_cycle", i), ev_cycle, tbl[i].cyc);
        chk($sformatf("tbl%0d_ltl", i), ev_ltl, tbl[i].ltl);
        chk($sformatf("tbl%0d_rep", i), ev_rep, tbl[i].rep);
      end
      tick();
    end

    // Overflow: six one-bit snapshots while stalled; the sixth is dropped.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      run = 1'b1; report_vec = 40'd1 << k; ev_ready = 1'b0;
      tick();
    end
    run = 1'b0; report_vec = '0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_cnt, 1);
    chk("ovf_valid", ev_valid, 1);
    chk("ovf_cycle", ev_cycle, 0);
    tick(); tick();
    chk("ovf_stall_cycle", ev_cycle, 0);
    chk("ovf_stall_rep", ev_rep, 0);
    run = 1'b1; report_vec = 40'h80;
    repeat (260) tick();
    run = 1'b0; report_vec = '0;
    chk("drop_saturate", drop_cnt, 255);
    chk("ovf_sticky", overflow, 1);
    ev_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (ev_valid) begin
        chk($sformatf("ovf_ev%0d_cycle", got), ev_cycle, got);
        chk($sformatf("ovf_ev%0d_ltl", got), ev_ltl, got / 4);
        chk($sformatf("ovf_ev%0d_rep", got), ev_rep, got % 4);
        got++;
      end
      tick();
    end
    chk("ovf_event_count", got, 5);
    chk("ovf_drained_busy", busy, 0);

    // run=0 blocks pushes and counting while a pending snapshot still drains.
    do_reset();
    drive_cycle(1'b1, 40'h0040_0204, 1'b0);
    for (int k = 0; k < 10; k++) drive_cycle(1'b0, rand_vec(), 1'b1);
    chk("run0_drained", evq.size(), 0);
    chk("run0_busy", busy, 0);
    drive_cycle(1'b1, 40'h1, 1'b1);
    for (int k = 0; k < 6; k++) drive_cycle(1'b0, '0, 1'b1);
    chk("run0_stamp_drained", evq.size(), 0);

    // Reset mid-emission discards everything and clears status.
    do_reset();
    run = 1'b1; report_vec = 40'h0000_1042; ev_ready = 1'b0;
    tick();
    report_vec = 40'h1;
    repeat (6) tick();
    run = 1'b0; report_vec = '0;
    chk("pre_rst_valid", ev_valid, 1);
    chk("pre_rst_drop", drop_cnt, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", ev_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_cycle", ev_cycle, 0);
    chk("mid_rst_ltl", ev_ltl, 0);
    ev_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("post_rst_quiet%0d", k), ev_valid, 0);
      tick();
    end

`ifdef MON8C2_SUMMARY_EN
    do_reset();
    ev_ready = 1'b1;
    run = 1'b1; report_vec = 40'h8;       tick();
    report_vec = '0;                      tick();
    report_vec = 40'h10_0000;             tick();
    run = 1'b0; report_vec = 40'h08_0000_0000; tick();
    chk("summary", summary, 40'h00_0010_0008);
    repeat (5) tick();
    chk("summary_hold", summary, 40'h00_0010_0008);
    do_reset();
    chk("summary_rst", summary, 0);
`endif

    // Random traffic against the model; pushes limited so the FIFO can never fill.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 7) != 0);
      rd = ($urandom_range(0, 3) != 0);
      v  = '0;
      if (!r && $urandom_range(0, 1) == 0) v = rand_vec();
      else if ($urandom_range(0, 2) == 0 && outstanding() < FIFO_DEPTH) v = rand_vec();
      drive_cycle(r, v, rd);
    end
    for (int c = 0; c < 400 && (evq.size() != 0 || busy); c++) drive_cycle(1'b0, '0, 1'b1);
    chk("rnd_drained", evq.size(), 0);
    chk("rnd_busy", busy, 0);
    chk("rnd_overflow", overflow, 0);
    chk("rnd_drop", drop_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
